// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, FSM state type and ALU flag indices
// for the issue/writeback controller.
package mips_pkg;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] BNE   = 6'b000101;
  localparam logic [5:0] ADDI  = 6'b001000;
  localparam logic [5:0] ADDIU = 6'b001001;
  localparam logic [5:0] SLTI  = 6'b001010;
  localparam logic [5:0] SLTIU = 6'b001011;
  localparam logic [5:0] ANDI  = 6'b001100;
  localparam logic [5:0] ORI   = 6'b001101;
  localparam logic [5:0] XORI  = 6'b001110;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam int ZF = 2;
  localparam int NF = 1;
  localparam int OF = 0;

endpackage

// File: rtl/regfile32.sv
// 32x32 GPR file: two async read ports, one sync write port,
// r0 hardwired to zero, synchronous clear.
module regfile32 (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data
);

  logic [31:0] gpr [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else if (we && (w_addr != 5'd0)) begin
      gpr[w_addr] <= w_data;
    end
  end

  assign ra_data = (ra_addr == 5'd0) ? 32'd0 : gpr[ra_addr];
  assign rb_data = (rb_addr == 5'd0) ? 32'd0 : gpr[rb_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback controller driving a single-cycle MIPS ALU:
// one instruction in flight, IDLE -> EXEC -> (MEM) -> WB.
module alu_issue
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_reg_a,
  output logic [31:0] alu_reg_b,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_en,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic        br_taken,
  output logic [31:0] br_offset,
  output logic        exc_ovf
);

  state_t      state;
  logic [4:0]  rt_q;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  logic [5:0]  op;
  logic [5:0]  fn;
  logic        writes;
  logic        is_mem;
  logic        is_br;
  logic        can_trap;
  logic        br_hit;
  logic        trap;
  logic [4:0]  dest;
  logic        unused_nf;

  assign unused_nf = alu_flags[NF];

  regfile32 u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_instr[25:21]),
    .rb_addr (in_instr[20:16]),
    .ra_data (rd_a),
    .rb_data (rd_b),
    .we      (wb_en),
    .w_addr  (wb_addr),
    .w_data  (wb_data)
  );

  always_comb begin
    op       = alu_instr[31:26];
    fn       = alu_instr[5:0];
    writes   = 1'b0;
    is_mem   = 1'b0;
    is_br    = 1'b0;
    can_trap = 1'b0;
    dest     = rt_q;
    unique case (1'b1)
      (op == RTYPE): begin
        writes   = 1'b1;
        dest     = alu_instr[15:11];
        can_trap = (fn == ADD) || (fn == SUB);
      end
      (op == ADDI): begin
        writes   = 1'b1;
        can_trap = 1'b1;
      end
      (op == ADDIU) || (op == ANDI) || (op == ORI) ||
      (op == XORI) || (op == SLTI) || (op == SLTIU): begin
        writes = 1'b1;
      end
      (op == LW): begin
        writes = 1'b1;
        is_mem = 1'b1;
      end
      (op == SW): begin
        is_mem = 1'b1;
      end
      (op == BEQ) || (op == BNE): begin
        is_br = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // The ALU zero flag tracks result == 0, so bne is its complement.
  assign br_hit = (op == BEQ) ? alu_flags[ZF] : ~alu_flags[ZF];
  assign trap   = can_trap & alu_flags[OF];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      rt_q      <= '0;
      alu_instr <= '0;
      alu_reg_a <= '0;
      alu_reg_b <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      br_valid  <= 1'b0;
      br_taken  <= 1'b0;
      br_offset <= '0;
      exc_ovf   <= 1'b0;
    end else begin
      wb_en    <= 1'b0;
      br_valid <= 1'b0;
      exc_ovf  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= EXEC;
            in_ready  <= 1'b0;
            alu_instr <= {in_instr[31:26], 5'b00000,
                          5'b00001, in_instr[15:0]};
            alu_reg_a <= rd_a;
            alu_reg_b <= rd_b;
            rt_q      <= in_instr[20:16];
          end
        end
        EXEC: begin
          wb_addr <= dest;
          if (is_mem) begin
            state     <= MEM;
            mem_req   <= 1'b1;
            mem_we    <= (op == SW);
            mem_addr  <= alu_result;
            mem_wdata <= alu_reg_b;
          end else begin
            state    <= WB;
            wb_data  <= alu_result;
            wb_en    <= writes & ~trap;
            exc_ovf  <= trap;
            br_valid <= is_br;
            if (is_br) begin
              br_taken  <= br_hit;
              br_offset <= {{14{alu_instr[15]}},
                            alu_instr[15:0], 2'b00};
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            state   <= WB;
            mem_req <= 1'b0;
            wb_en   <= ~mem_we;
            if (!mem_we) wb_data <= mem_rdata;
          end
        end
        WB: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue with a behavioural MIPS ALU attached and a
// queue of expected writeback/branch/trap events.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [31:0] alu_instr;
  logic [31:0] alu_reg_a;
  logic [31:0] alu_reg_b;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        exc_ovf;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          kind;
    logic [4:0]  a;
    logic [31:0] d;
    logic        t;
  } ev_t;

  ev_t exp_q[$];

  always #5 clk = ~clk;

  alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .alu_instr  (alu_instr),
    .alu_reg_a  (alu_reg_a),
    .alu_reg_b  (alu_reg_b),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .br_valid   (br_valid),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .exc_ovf    (exc_ovf)
  );

  // ALU model; overflow is flagged for every add/sub form so the
  // block's own trap gating is what decides addu/subu behaviour.
  always_comb begin
    logic [31:0] a, b, se, r;
    logic [4:0]  sh;
    logic        ov;
    a  = alu_reg_a;
    b  = alu_reg_b;
    sh = alu_instr[10:6];
    se = {{16{alu_instr[15]}}, alu_instr[15:0]};
    r  = '0;
    ov = 1'b0;
    case (alu_instr[31:26])
      6'h00: begin
        case (alu_instr[5:0])
          6'h00: r = b << sh;
          6'h02: r = b >> sh;
          6'h03: r = $signed(b) >>> sh;
          6'h04: r = b << a[4:0];
          6'h06: r = b >> a[4:0];
          6'h07: r = $signed(b) >>> a[4:0];
          6'h20, 6'h21: begin
            r  = a + b;
            ov = (a[31] == b[31]) && (r[31] != a[31]);
          end
          6'h22, 6'h23: begin
            r  = a - b;
            ov = (a[31] != b[31]) && (r[31] != a[31]);
          end
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h27: r = ~(a | b);
          6'h2a: r = {31'd0, $signed(a) < $signed(b)};
          6'h2b: r = {31'd0, a < b};
          default: r = '0;
        endcase
      end
      6'h08, 6'h09, 6'h23, 6'h2b: begin
        r  = a + se;
        ov = (a[31] == se[31]) && (r[31] != a[31]);
      end
      6'h0a: r = {31'd0, $signed(a) < $signed(se)};
      6'h0b: r = {31'd0, a < se};
      6'h0c: r = a & {16'd0, alu_instr[15:0]};
      6'h0d: r = a | {16'd0, alu_instr[15:0]};
      6'h0e: r = a ^ {16'd0, alu_instr[15:0]};
      6'h04, 6'h05: begin
        r  = a - b;
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = '0;
    endcase
    alu_result = r;
    alu_flags  = {r == 32'd0, r[31], ov};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rt_ins(input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] it_ins(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt,
      input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic exp_wb(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back('{kind: 0, a: a, d: d, t: 1'b0});
  endtask

  task automatic exp_br(input logic t, input logic [31:0] off);
    exp_q.push_back('{kind: 1, a: 5'd0, d: off, t: t});
  endtask

  task automatic exp_ovf();
    exp_q.push_back('{kind: 2, a: 5'd0, d: 32'd0, t: 1'b0});
  endtask

  always @(negedge clk) begin
    if (!rst && (wb_en || br_valid || exc_ovf)) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", {29'd0, wb_en, br_valid, exc_ovf}, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        case (e.kind)
          0: begin
            chk("wb_en", wb_en, 1);
            chk("wb_addr", wb_addr, e.a);
            chk("wb_data", wb_data, e.d);
            chk("wb_ovf", exc_ovf, 0);
          end
          1: begin
            chk("br_valid", br_valid, 1);
            chk("br_taken", br_taken, e.t);
            chk("br_offset", br_offset, e.d);
            chk("br_wb_en", wb_en, 0);
          end
          default: begin
            chk("exc_ovf", exc_ovf, 1);
            chk("ovf_wb_en", wb_en, 0);
          end
        endcase
      end
    end
  end

  task automatic accept(input logic [31:0] ins);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_instr = ins;
    @(posedge clk);
    #1 in_valid = 1'b0;
    in_instr = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("alu_instr", alu_instr,
        {ins[31:26], 5'd0, 5'd1, ins[15:0]});
    chk("busy_n1", in_ready, 0);
  endtask

  task automatic issue(input logic [31:0] ins, input bit ops = 0,
                       input logic [31:0] ea = 0,
                       input logic [31:0] eb = 0);
    logic had;
    had = (exp_q.size() != 0);
    accept(ins);
    if (ops) begin
      chk("reg_a", alu_reg_a, ea);
      chk("reg_b", alu_reg_b, eb);
    end
    @(negedge clk);
    chk("pulse_at_n2", wb_en | br_valid | exc_ovf, had);
    chk("busy_n2", in_ready, 0);
    @(negedge clk);
    chk("ready_n3", in_ready, 1);
    chk("sb_drain", exp_q.size(), 0);
  endtask

  task automatic issue_mem(input logic [31:0] ins,
      input logic [31:0] addr, input bit we,
      input logic [31:0] wd, input int delay,
      input logic [31:0] rdata);
    logic had;
    had = (exp_q.size() != 0);
    accept(ins);
    @(negedge clk);
    chk("mem_req", mem_req, 1);
    chk("mem_addr", mem_addr, addr);
    chk("mem_we", mem_we, we);
    if (we) chk("mem_wdata", mem_wdata, wd);
    for (int k = 0; k < delay; k++) begin
      @(negedge clk);
      chk("mem_hold", mem_req, 1);
      chk("mem_no_wb", wb_en, 0);
    end
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    @(posedge clk);
    #1 mem_ack = 1'b0;
    mem_rdata = 32'h0;
    @(negedge clk);
    chk("pulse_after_ack", wb_en, had);
    chk("mem_req_drop", mem_req, 0);
    @(negedge clk);
    chk("ready_after_mem", in_ready, 1);
    chk("sb_drain_mem", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_alu_instr", alu_instr, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_pulses", {wb_en, br_valid, exc_ovf}, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_br_offset", br_offset, 0);
    rst = 1'b0;

    exp_wb(1, 32'd5);
    issue(it_ins(6'h08, 0, 1, 16'd5), 1, 0, 0);

    exp_wb(2, 32'hFFFF_FFFF);
    issue(it_ins(6'h08, 0, 2, 16'hFFFF));
    exp_wb(2, 32'h7FFF_FFFF);
    issue(rt_ins(0, 2, 2, 1, 6'h02));
    exp_wb(3, 32'd1);
    issue(it_ins(6'h08, 0, 3, 16'd1));

    exp_ovf();
    issue(rt_ins(2, 3, 4, 0, 6'h20), 1, 32'h7FFF_FFFF, 32'd1);
    exp_wb(13, 32'd0);
    issue(rt_ins(4, 0, 13, 0, 6'h25), 1, 0, 0);
    exp_wb(4, 32'h8000_0000);
    issue(rt_ins(2, 3, 4, 0, 6'h21));
    exp_ovf();
    issue(rt_ins(4, 3, 14, 0, 6'h22));
    exp_wb(14, 32'h7FFF_FFFF);
    issue(rt_ins(4, 3, 14, 0, 6'h23));
    exp_wb(16, 32'd1);
    issue(it_ins(6'h0a, 4, 16, 16'd1));
    exp_wb(17, 32'h0000_ABCD);
    issue(it_ins(6'h0d, 0, 17, 16'hABCD));

    exp_wb(2, 32'd5);
    issue(it_ins(6'h08, 0, 2, 16'd5));
    exp_br(1'b1, 32'd12);
    issue(it_ins(6'h04, 1, 2, 16'd3));
    exp_br(1'b0, 32'd12);
    issue(it_ins(6'h05, 1, 2, 16'd3));
    exp_wb(2, 32'd6);
    issue(it_ins(6'h08, 0, 2, 16'd6));
    exp_br(1'b1, 32'd12);
    issue(it_ins(6'h05, 1, 2, 16'd3));
    exp_br(1'b1, 32'hFFFF_FFFC);
    issue(it_ins(6'h04, 1, 1, 16'hFFFF));

    exp_wb(1, 32'h100);
    issue(it_ins(6'h08, 0, 1, 16'h0100));
    exp_wb(5, 32'hDEAD_BEEF);
    issue_mem(it_ins(6'h23, 1, 5, 16'hFFFC), 32'hFC, 0, 0,
              3, 32'hDEAD_BEEF);
    issue_mem(it_ins(6'h2b, 1, 5, 16'd8), 32'h108, 1,
              32'hDEAD_BEEF, 0, 32'h1234_5678);

    exp_wb(6, 32'hFFFF_FFFF);
    issue(it_ins(6'h08, 0, 6, 16'hFFFF));
    exp_wb(6, 32'hF000_0000);
    issue(rt_ins(0, 6, 6, 28, 6'h00));
    exp_wb(7, 32'd4);
    issue(it_ins(6'h08, 0, 7, 16'd4));
    exp_wb(8, 32'hFF00_0000);
    issue(rt_ins(7, 6, 8, 0, 6'h07));
    exp_wb(9, 32'd0);
    issue(rt_ins(0, 6, 9, 4, 6'h00));

    issue(32'h0800_0010);
    exp_wb(0, 32'd7);
    issue(it_ins(6'h08, 0, 0, 16'd7));
    exp_wb(15, 32'd0);
    issue(rt_ins(0, 0, 15, 0, 6'h25), 1, 0, 0);

    accept(it_ins(6'h23, 1, 11, 16'd0));
    @(negedge clk);
    chk("pre_rst_mem_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem_req", mem_req, 0);
    chk("rst_mid_ready", in_ready, 1);
    chk("rst_mid_pulses", {wb_en, br_valid, exc_ovf}, 0);
    rst = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("post_rst_no_wb", wb_en, 0);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    exp_wb(12, 32'd0);
    issue(rt_ins(1, 5, 12, 0, 6'h20), 1, 0, 0);

    repeat (3) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Multi-cycle issue/writeback controller that drives the single-cycle MIPS `alu` block from the other side of its interface. It accepts one fetched instruction at a time over a valid/ready handshake, reads operands from an internal 32×32 register file, and presents `instruction`/`regA`/`regB` to the ALU. It then consumes `result`/`flags` to perform register writeback, branch resolution, overflow trapping and `lw`/`sw` memory requests.

## Interface
- No parameters; all widths fixed at 32-bit data, 5-bit register address.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in 1: fetched instruction available.
- `in_instr` in 32: MIPS instruction word.
- `in_ready` out 1: block can accept; high only in IDLE.
- `alu_instr` out 32: instruction to ALU, rs field forced to 00000 and rt field forced to 00001.
- `alu_reg_a` out 32: GPR[rs].
- `alu_reg_b` out 32: GPR[rt].
- `alu_result` in 32: ALU result, combinational from the `alu_*` outputs.
- `alu_flags` in 3: [2] zero, [1] negative, [0] overflow.
- `mem_req` out 1: memory request, held until acknowledged.
- `mem_we` out 1: 1 = sw, 0 = lw.
- `mem_addr` out 32: ALU effective address.
- `mem_wdata` out 32: GPR[rt] for sw.
- `mem_ack` in 1: request complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: load data.
- `wb_en` out 1: one-cycle pulse, register written.
- `wb_addr` out 5: destination register.
- `wb_data` out 32: value written.
- `br_valid` out 1: one-cycle pulse, branch resolved.
- `br_taken` out 1: branch outcome, qualified by `br_valid`.
- `br_offset` out 32: sign-extended imm << 2, qualified by `br_valid`.
- `exc_ovf` out 1: one-cycle pulse, add/addi/sub overflow, write suppressed.

## Operation
- FSM states: IDLE, EXEC, MEM, WB.
  - IDLE → EXEC on `in_valid & in_ready`.
  - EXEC → MEM for lw (opcode 100011) and sw (opcode 101011).
  - EXEC → WB for all other instructions.
  - MEM → WB on `mem_ack`.
  - WB → IDLE unconditionally.
- On accept, the block registers:
  - `alu_instr` = {in_instr[31:26], 5'b00000, 5'b00001, in_instr[15:0]}.
  - `alu_reg_a` = GPR[in_instr[25:21]].
  - `alu_reg_b` = GPR[in_instr[20:16]].
- The field rewrite makes ALU shifts and lw/sw select the correct operand: sll/srl/sra shift GPR[rt], sllv/srlv/srav shift GPR[rt] by GPR[rs], and address = GPR[rs] + imm.
- Destination register:
  - R-type (opcode 000000): rd.
  - addi/addiu/andi/ori/xori/slti/sltiu/lw: rt.
  - beq/bne/sw: no write.
  - Any other opcode: executed as a NOP, no write and no pulse.
- Results captured at the end of EXEC:
  - `alu_result` into `wb_data` or `mem_addr`.
  - `alu_flags` into internal flag registers.
- Branches:
  - beq taken = flags[2] == 1.
  - bne taken = flags[2] == 0, because the ALU zero flag always reflects result == 0.
- Overflow: for add, addi or sub with flags[0] = 1, the block suppresses `wb_en` and pulses `exc_ovf` in WB. addu/addiu/subu never trap.
- lw: `wb_data` = `mem_rdata` captured on `mem_ack`.
- sw: no writeback.
- Register file: written in WB when `wb_en`=1. Writes to r0 are dropped, and r0 always reads 0.
- `in_valid` outside IDLE is ignored. No instruction is ever overlapped, so no forwarding or hazard logic exists.

## Timing
- Accept at cycle N. The `alu_*` outputs are valid from N+1 and held stable until the next accept.
- Non-memory instruction: WB at N+2, where `wb_en`/`br_valid`/`exc_ovf` pulse. `in_ready`=1 again at N+3.
- Memory instruction:
  - `mem_req`=1 from N+2 until the cycle `mem_ack`=1, inclusive.
  - If `mem_ack` arrives at cycle M, WB is at M+1 and IDLE at M+2.
  - `mem_ack` arriving in the first MEM cycle is legal.
- All outputs are registered. `mem_ack` outside MEM is ignored.
- Reset values: every output 0, except `in_ready`=1 after the first post-reset edge. The FSM is in IDLE and all 32 GPRs are 0.
- Reset asserted mid-operation, including during MEM with `mem_req` high: the next edge returns the block to IDLE, drops `mem_req`, and fires no pulses. A pending load is discarded.

## Structure
- Package `mips_pkg` holds:
  - opcode constants (ADDI, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LW, SW, BEQ, BNE, RTYPE);
  - funct constants (ADD, SUB);
  - the FSM state enum;
  - flag bit indices ZF=2, NF=1, OF=0.
- Sub-module `regfile32`: two combinational read ports, one synchronous write port, r0 hardwired to zero, synchronous clear on `rst`.

## Test plan
- Reset, then accept addi r1,r0,5 with the real `alu` attached → `alu_instr` shows rs=0/rt=1; WB at N+2 with `wb_addr`=1, `wb_data`=5; `in_ready` returns at N+3.
- Preload r2=0x7FFFFFFF, r3=1, issue add r4,r2,r3 → `exc_ovf`=1, `wb_en`=0, r4 stays 0. Repeat with addu → `wb_data`=0x80000000.
- r1=5, r2=5: beq r1,r2,+3 → `br_valid`=1, `br_taken`=1, `br_offset`=12. Same operands with bne → `br_taken`=0; bne with r2=6 → `br_taken`=1.
- r1=0x100: lw r5,-4(r1) → `mem_addr`=0xFC; hold `mem_ack` low 3 cycles then ack with `mem_rdata`=0xDEADBEEF → `wb_addr`=5, `wb_data`=0xDEADBEEF one cycle after ack.
- r6=0xF0000000, r7=4: srav r8,r6,r7 → `wb_data`=0xFF000000. sll r9,r6,4 → `wb_data`=0.
- Assert `rst` during MEM with `mem_req`=1 → next cycle `mem_req`=0, FSM in IDLE, no `wb_en` pulse, GPR reads 0.
